axil_regbank: RTL and testbench

AXIL_REGBANK -- requirements
Module: axil_regbank

---
 rtl/axil_regbank.sv | 161 ++++++++++++++++
 tb/tb_axil_regbank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regbank.sv
// rtl/axil_regbank.sv - AXI4-Lite register bank with RW/RO registers and per-register write strobes
//
// Ports:
//   ACLK, ARESETN            clock, synchronous active-low reset
//   AW*/W*/B*                AXI4-Lite write address, data, response channels
//   AR*/R*                   AXI4-Lite read address and data channels
//   regs_out                 flattened RW register contents (RO slices read 0)
//   status_in                flattened read values for RO registers
//   wr_pulse                 one-cycle strobe per register on each committed write

module axil_regbank #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_REGS   = 8,
    parameter int C_ADDR_WIDTH = 6,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]           AWADDR,
    input  logic [2:0]                        AWPROT,
    input  logic                              AWVALID,
    output logic                              AWREADY,
    input  logic [C_DATA_WIDTH-1:0]           WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]         WSTRB,
    input  logic                              WVALID,
    output logic                              WREADY,
    output logic [1:0]                        BRESP,
    output logic                              BVALID,
    input  logic                              BREADY,
    input  logic [C_ADDR_WIDTH-1:0]           ARADDR,
    input  logic [2:0]                        ARPROT,
    input  logic                              ARVALID,
    output logic                              ARREADY,
    output logic [C_DATA_WIDTH-1:0]           RDATA,
    output logic [1:0]                        RRESP,
    output logic                              RVALID,
    input  logic                              RREADY,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] regs_out,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
    output logic [C_NUM_REGS-1:0]             wr_pulse
);

    localparam int BYTES = C_DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = C_ADDR_WIDTH - OFFS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [C_DATA_WIDTH-1:0] regs [C_NUM_REGS];

    // Held to 0 by reset so every ready stays low until the first edge after release.
    logic                    ready_en;
    logic                    aw_held;
    logic [IDX_W-1:0]        aw_idx;
    logic                    w_held;
    logic [C_DATA_WIDTH-1:0] w_data;
    logic [BYTES-1:0]        w_strb;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic [C_DATA_WIDTH-1:0] wr_data, rd_val;
    logic [BYTES-1:0]        wr_strb;
    logic [C_NUM_REGS-1:0]   wr_sel;
    logic                    wr_ok, rd_hit;

    logic unused;
    assign unused = ^{AWPROT, ARPROT, AWADDR[OFFS-1:0], ARADDR[OFFS-1:0], status_in};

    assign AWREADY = ready_en && !aw_held && !BVALID;
    assign WREADY  = ready_en && !w_held && !BVALID;
    assign ARREADY = ready_en && !RVALID;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // A channel is available if already held or handshaking this edge, so a
    // same-cycle AW/W pair commits on its own handshake edge.
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = aw_held ? aw_idx : AWADDR[C_ADDR_WIDTH-1:OFFS];
    assign wr_data = w_held ? w_data : WDATA;
    assign wr_strb = w_held ? w_strb : WSTRB;
    assign rd_idx  = ARADDR[C_ADDR_WIDTH-1:OFFS];

    always_comb begin
        wr_ok  = 1'b0;
        wr_sel = '0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (int'(wr_idx) == i && !C_RO_MASK[i]) begin
                wr_ok     = 1'b1;
                wr_sel[i] = 1'b1;
            end
            if (int'(rd_idx) == i) begin
                rd_hit = 1'b1;
                rd_val = C_RO_MASK[i] ? status_in[i*C_DATA_WIDTH +: C_DATA_WIDTH] : regs[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
            wr_pulse <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            wr_pulse <= '0;

            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                BVALID   <= 1'b1;
                BRESP    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                wr_pulse <= wr_sel;
                for (int i = 0; i < C_NUM_REGS; i++)
                    for (int b = 0; b < BYTES; b++)
                        if (wr_sel[i] && wr_strb[b])
                            regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_idx  <= AWADDR[C_ADDR_WIDTH-1:OFFS];
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= WDATA;
                    w_strb <= WSTRB;
                end
            end

            if (BVALID && BREADY) BVALID <= 1'b0;

            // rd_val is taken from the current register array, so a commit on
            // the same edge is not yet visible to this read.
            if (ar_hs) begin
                RVALID <= 1'b1;
                RDATA  <= rd_val;
                RRESP  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign regs_out[g*C_DATA_WIDTH +: C_DATA_WIDTH] = C_RO_MASK[g] ? '0 : regs[g];
    end

endmodule

// File: tb/tb_axil_regbank.sv
// tb/tb_axil_regbank.sv - self-checking bench for axil_regbank

module tb_axil_regbank;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [5:0]  AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [255:0] regs_out;
    logic [255:0] status_in;
    logic [7:0]  wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    axil_regbank #(
        .C_DATA_WIDTH(32),
        .C_NUM_REGS(8),
        .C_ADDR_WIDTH(6),
        .C_RO_MASK(8'h80)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_out(regs_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp, input logic [7:0] pulse);
        int n = 0;
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
        while (!(AWREADY && WREADY) && n < 20) begin step(); n++; end
        chk("wr_ready", {62'd0, AWREADY, WREADY}, 64'd3);
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("bvalid_set", BVALID, 1);
        chk("bresp", BRESP, resp);
        chk("wr_pulse", wr_pulse, pulse);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk("bvalid_clr", BVALID, 0);
        chk("wr_pulse_clr", wr_pulse, 0);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin step(); n++; end
        chk("ar_ready", ARREADY, 1);
        step();
        ARVALID = 1'b0;
        chk("rvalid_set", RVALID, 1);
        chk("rdata", RDATA, d);
        chk("rresp", RRESP, resp);
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        chk("rvalid_clr", RVALID, 0);
    endtask

    // Presents one channel three cycles before the other, with BREADY held low
    // for five cycles after the response appears.
    task automatic split_write(input bit aw_first, input logic [5:0] a, input logic [31:0] d,
                               input logic [7:0] pulse);
        AWADDR = a; WDATA = d; WSTRB = 4'hF;
        if (aw_first) AWVALID = 1'b1; else WVALID = 1'b1;
        chk("split_first_ready", aw_first ? AWREADY : WREADY, 1);
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("split_first_held", aw_first ? AWREADY : WREADY, 0);
            chk("split_no_early_b", BVALID, 0);
            chk("split_no_early_pulse", wr_pulse, 0);
            step();
        end
        if (aw_first) WVALID = 1'b1; else AWVALID = 1'b1;
        chk("split_second_ready", aw_first ? WREADY : AWREADY, 1);
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("split_bvalid", BVALID, 1);
        chk("split_bresp", BRESP, 2'b00);
        chk("split_pulse", wr_pulse, pulse);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("split_b_hold", BVALID, 1);
            chk("split_pulse_once", wr_pulse, 0);
            chk("split_aw_blocked", AWREADY, 0);
            chk("split_w_blocked", WREADY, 0);
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk("split_b_done", BVALID, 0);
        chk("split_aw_free", AWREADY, 1);
        chk("split_w_free", WREADY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1, 6'h00, 32'h1, 4'hF, 32'h1, 2'b00, 8'h01};
        vecs[1]  = '{1, 6'h04, 32'h2, 4'hF, 32'h2, 2'b00, 8'h02};
        vecs[2]  = '{1, 6'h08, 32'h3, 4'hF, 32'h3, 2'b00, 8'h04};
        vecs[3]  = '{1, 6'h0C, 32'h4, 4'hF, 32'h4, 2'b00, 8'h08};
        vecs[4]  = '{0, 6'h00, 32'h0, 4'h0, 32'h1, 2'b00, 8'h00};
        vecs[5]  = '{0, 6'h04, 32'h0, 4'h0, 32'h2, 2'b00, 8'h00};
        vecs[6]  = '{0, 6'h08, 32'h0, 4'h0, 32'h3, 2'b00, 8'h00};
        vecs[7]  = '{0, 6'h0C, 32'h0, 4'h0, 32'h4, 2'b00, 8'h00};
        vecs[8]  = '{1, 6'h00, 32'hAABBCCDD, 4'b0010, 32'h0000CC01, 2'b00, 8'h01};
        vecs[9]  = '{0, 6'h00, 32'h0, 4'h0, 32'h0000CC01, 2'b00, 8'h00};
        vecs[10] = '{1, 6'h1C, 32'h12345678, 4'hF, 32'h0, 2'b10, 8'h00};
        vecs[11] = '{0, 6'h1C, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 8'h00};
        vecs[12] = '{0, 6'h20, 32'h0, 4'h0, 32'h0, 2'b10, 8'h00};
        vecs[13] = '{1, 6'h20, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b10, 8'h00};
        vecs[14] = '{1, 6'h07, 32'h11223344, 4'hF, 32'h11223344, 2'b00, 8'h02};
        vecs[15] = '{0, 6'h06, 32'h0, 4'h0, 32'h11223344, 2'b00, 8'h00};

        ARESETN = 1'b0;
        AWADDR = '0; AWPROT = 3'd0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = 3'd0; ARVALID = 1'b0; RREADY = 1'b0;
        status_in = '0;
        status_in[7*32 +: 32] = 32'hDEADBEEF;
        status_in[3*32 +: 32] = 32'h12345678;

        step(); step(); step();
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_outs", {wr_pulse, BRESP, RRESP, RDATA}, 0);
        chk("rst_regs_out", regs_out[63:0] | regs_out[255:192], 0);
        ARESETN = 1'b1;
        step();
        chk("rel_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, vecs[i].exp_pulse);
                if (vecs[i].exp_resp == 2'b00)
                    chk($sformatf("regs_out_v%0d", i),
                        regs_out[vecs[i].addr[5:2]*32 +: 32], vecs[i].exp_data);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
            end
        end
        chk("regs_out_ro_zero", regs_out[255:224], 0);
        chk("regs_out_r2", regs_out[95:64], 32'h3);
        chk("regs_out_r3", regs_out[127:96], 32'h4);

        split_write(1'b0, 6'h08, 32'hA5, 8'h04);
        split_write(1'b1, 6'h0C, 32'h5A, 8'h08);
        chk("split_r2", regs_out[95:64], 32'hA5);
        chk("split_r3", regs_out[127:96], 32'h5A);

        // Commit and AR handshake on the same edge return the pre-write value.
        do_write(6'h08, 32'h5, 4'hF, 2'b00, 8'h04);
        AWADDR = 6'h08; WDATA = 32'h9; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 6'h08; ARVALID = 1'b1;
        chk("coll_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("coll_rvalid", RVALID, 1);
        chk("coll_rdata_old", RDATA, 32'h5);
        chk("coll_bvalid", BVALID, 1);
        chk("coll_regs_out_new", regs_out[95:64], 32'h9);
        BREADY = 1'b1; RREADY = 1'b1;
        step();
        BREADY = 1'b0; RREADY = 1'b0;
        do_read(6'h08, 32'h9, 2'b00);

        // Reset while AW is held without W and a read response is pending.
        AWADDR = 6'h00; AWVALID = 1'b1; ARADDR = 6'h04; ARVALID = 1'b1;
        step();
        AWVALID = 1'b0; ARVALID = 1'b0;
        chk("pre_rst_rvalid", RVALID, 1);
        chk("pre_rst_aw_held", AWREADY, 0);
        ARESETN = 1'b0;
        step();
        chk("mid_rst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 0);
        chk("mid_rst_valid", {62'd0, BVALID, RVALID}, 0);
        chk("mid_rst_outs", {wr_pulse, BRESP, RRESP, RDATA}, 0);
        chk("mid_rst_regs", regs_out[127:0], 0);
        ARESETN = 1'b1;
        step();
        chk("post_rst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
        split_write(1'b0, 6'h04, 32'h7, 8'h02);
        do_read(6'h04, 32'h7, 2'b00);
        do_read(6'h00, 32'h0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
